floo_vc_output_alloc: RTL and testbench
=======================================

Name: floo_vc_output_alloc

Overview:
Per-output-port VC allocation controller for the virtual-channel router; one instance per output port. Sits after the global switch allocator and grants an output VC to the winning input.
- Head flits get a free downstream VC: preferred VC first, else the first usable VC.
- A multi-flit packet owns its VC until its tail flit is granted (wormhole lock).
- Owns the downstream credit counters for its port and registers the grant into the ST stage.

Parameters:
NumVC, 4, number of downstream VCs on this output.
NumVCWidth, 2, width of VC ids; must satisfy 2**NumVCWidth >= NumVC.
VCDepth, 2, downstream buffer depth per VC; also the credit reset value.
VCDepthWidth, $clog2(VCDepth+1), credit counter width.
NumInputs, 5, number of requesters, each an input port/VC pair identified by index.
InputIdWidth, $clog2(NumInputs), requester index width.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous reset, active-low
req_v_i  input  1  global SA winner valid this cycle
req_input_id_i  input  InputIdWidth  requester index of the winner
req_head_i  input  1  flit is a head flit
req_last_i  input  1  flit is the tail flit; head and last together mean a single-flit packet
req_pref_vc_i  input  NumVCWidth  preferred VC from look-ahead routing
credit_v_i  input  1  credit returned from downstream
credit_id_i  input  NumVCWidth  VC of the returned credit
vc_assignment_v_o  output  1  combinational grant; drives the global SA arbiter update
vc_assignment_id_o  output  NumVCWidth  combinational granted VC
st_v_o  output  1  registered grant into the ST stage
st_vc_id_o  output  NumVCWidth  registered granted VC
st_input_id_o  output  InputIdWidth  registered requester index
vc_busy_o  output  NumVC  per-VC lock state
credit_counter_o  output  NumVC*VCDepthWidth  per-VC credit counts

Behaviour:
- Reset (asynchronous, active-low; also when asserted mid-operation):
  - all credit counters = VCDepth;
  - all busy bits = 0 and all owner entries = 0;
  - st_v_o = 0, st_vc_id_o = 0, st_input_id_o = 0.
- Per-VC state: busy bit, owner index (InputIdWidth) and credit counter.
  - Idle: busy = 0. Goes to Locked on a granted head with last = 0; owner latched from req_input_id_i.
  - Locked: busy = 1. Back to Idle on a granted tail whose requester matches the owner.
- A VC is usable when busy = 0 and its credit is > 0.
- Head request:
  - Pick req_pref_vc_i if it is usable; otherwise the lowest-index usable VC.
  - If no VC is usable: vc_assignment_v_o = 0 and no state change.
- Body/tail request:
  - Look up the VC that is busy and whose owner equals req_input_id_i.
  - Grant if that VC's credit is > 0.
  - If no VC is owned by that requester: no grant; a simulation assertion fires.
- A head from a requester that already owns a VC: no grant; a simulation assertion fires.
- Grant path: combinational, same cycle as req_v_i, so it does not add a pipeline stage.
  - vc_assignment_id_o = 0 whenever there is no grant.
- Every grant decrements the granted VC's credit (credits are consumed at allocation).
- Credit return: credit_v_i increments the counter for credit_id_i at the next edge.
  - A grant and a credit return on the same VC in the same cycle leave the counter unchanged.
  - Credits are never granted through in the same cycle as they return.
  - Increment when the counter is already at VCDepth: counter holds; assertion fires.
  - credit_id_i >= NumVC: ignored; assertion fires.
- Single-flit packet (head and last): consumes one credit; busy stays 0.
- Tail grant and a new head in the next cycle: the freed VC is usable in that next cycle.
- ST register: at the edge after a grant, st_v_o = 1 with the VC and requester index. Otherwise st_v_o = 0 and the id outputs hold their previous values.
- At most one grant per cycle.

Test Plan:
- Reset, then head (id 2, pref 1, last 0) -> vc_assignment_v_o = 1, id 1; next cycle st_v_o = 1, st_vc_id_o = 1, st_input_id_o = 2, vc_busy_o = 4'b0010, credit[1] = 1.
- Continue id 2: body then tail -> both granted on VC1; credit[1] = 0 after the tail is consumed (body grant takes 1→0, so the tail waits with grant 0 until a credit arrives); after a credit_v_i for VC1 the tail is granted and vc_busy_o[1] = 0.
- VC1 busy (owner 2); head from id 3 with pref 1 -> granted VC0 (lowest usable); vc_busy_o = 4'b0011.
- All VCs busy, or every free VC at credit 0; head request -> vc_assignment_v_o = 0; counters and busy bits unchanged.
- Body grant on VC2 (credit 2) plus credit_v_i on VC2 in the same cycle -> credit[2] stays 2.
- Assert rst_ni low while VC0 and VC3 are locked -> all outputs return to reset values immediately; after release a head with pref 3 is granted VC3.

Source files
------------

// File: rtl/floo_vc_output_alloc.sv
// floo_vc_output_alloc
//   Per-output-port VC allocator. Sits after the global switch allocator and
//   grants a downstream VC to the winning input. It also owns the downstream
//   credit counters for the port and registers the grant into the ST stage.
//
//   Head flits take the preferred VC if it is usable. Otherwise they take the
//   lowest-index usable VC. A VC is usable when it is not locked and its
//   credit is non-zero. A multi-flit packet locks its VC until its tail flit
//   is granted.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_*_i                switch-allocator winner: valid, requester index,
//                          head/tail flags, preferred VC
//   credit_v_i/credit_id_i credit returned from downstream
//   vc_assignment_*_o      combinational grant (same cycle as req_v_i)
//   st_*_o                 registered grant into the ST stage
//   vc_busy_o              per-VC lock bits
//   credit_counter_o       per-VC credit counts, VC0 in the LSBs
module floo_vc_output_alloc #(
  parameter int NumVC        = 4,
  parameter int NumVCWidth   = 2,
  parameter int VCDepth      = 2,
  parameter int VCDepthWidth = $clog2(VCDepth + 1),
  parameter int NumInputs    = 5,
  parameter int InputIdWidth = $clog2(NumInputs)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_v_i,
  input  logic [InputIdWidth-1:0]       req_input_id_i,
  input  logic                          req_head_i,
  input  logic                          req_last_i,
  input  logic [NumVCWidth-1:0]         req_pref_vc_i,
  input  logic                          credit_v_i,
  input  logic [NumVCWidth-1:0]         credit_id_i,
  output logic                          vc_assignment_v_o,
  output logic [NumVCWidth-1:0]         vc_assignment_id_o,
  output logic                          st_v_o,
  output logic [NumVCWidth-1:0]         st_vc_id_o,
  output logic [InputIdWidth-1:0]       st_input_id_o,
  output logic [NumVC-1:0]              vc_busy_o,
  output logic [NumVC*VCDepthWidth-1:0] credit_counter_o
);

  logic [NumVC-1:0]        busy_q;
  logic [InputIdWidth-1:0] owner_q  [NumVC];
  logic [VCDepthWidth-1:0] credit_q [NumVC];

  logic [NumVC-1:0]        usable;
  logic                    own_found;
  logic [NumVCWidth-1:0]   own_vc;
  logic                    free_found;
  logic [NumVCWidth-1:0]   free_vc;
  logic                    pref_ok;
  logic                    grant;
  logic [NumVCWidth-1:0]   grant_vc;
  logic                    credit_overflow;

  always_comb begin
    usable     = '0;
    own_found  = 1'b0;
    own_vc     = '0;
    free_found = 1'b0;
    free_vc    = '0;
    for (int v = 0; v < NumVC; v++) begin
      usable[v] = !busy_q[v] && (credit_q[v] != '0);
      if (!own_found && busy_q[v] && (owner_q[v] == req_input_id_i)) begin
        own_found = 1'b1;
        own_vc    = NumVCWidth'(v);
      end
      if (!free_found && usable[v]) begin
        free_found = 1'b1;
        free_vc    = NumVCWidth'(v);
      end
    end
    pref_ok = (int'(req_pref_vc_i) < NumVC) && usable[req_pref_vc_i];

    grant    = 1'b0;
    grant_vc = '0;
    if (req_v_i) begin
      if (req_head_i) begin
        // A head from a requester that already holds a VC is illegal.
        if (!own_found) begin
          if (pref_ok) begin
            grant    = 1'b1;
            grant_vc = req_pref_vc_i;
          end else if (free_found) begin
            grant    = 1'b1;
            grant_vc = free_vc;
          end
        end
      end else if (own_found && (credit_q[own_vc] != '0)) begin
        grant    = 1'b1;
        grant_vc = own_vc;
      end
    end
  end

  assign vc_assignment_v_o  = grant;
  assign vc_assignment_id_o = grant_vc;
  assign vc_busy_o          = busy_q;

  always_comb begin
    credit_counter_o = '0;
    credit_overflow  = 1'b0;
    for (int v = 0; v < NumVC; v++) begin
      credit_counter_o[v*VCDepthWidth +: VCDepthWidth] = credit_q[v];
      if (credit_v_i && (credit_id_i == NumVCWidth'(v)) &&
          (credit_q[v] == VCDepthWidth'(VCDepth)) &&
          !(grant && (grant_vc == NumVCWidth'(v))))
        credit_overflow = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q        <= '0;
      st_v_o        <= 1'b0;
      st_vc_id_o    <= '0;
      st_input_id_o <= '0;
      for (int v = 0; v < NumVC; v++) begin
        owner_q[v]  <= '0;
        credit_q[v] <= VCDepthWidth'(VCDepth);
      end
    end else begin
      st_v_o <= grant;
      if (grant) begin
        st_vc_id_o    <= grant_vc;
        st_input_id_o <= req_input_id_i;
      end
      for (int v = 0; v < NumVC; v++) begin
        // A grant and a returned credit on the same VC cancel out. A return
        // into a full counter is dropped.
        if (credit_v_i && (credit_id_i == NumVCWidth'(v))) begin
          if (!(grant && (grant_vc == NumVCWidth'(v))) &&
              (credit_q[v] != VCDepthWidth'(VCDepth)))
            credit_q[v] <= credit_q[v] + 1'b1;
        end else if (grant && (grant_vc == NumVCWidth'(v))) begin
          credit_q[v] <= credit_q[v] - 1'b1;
        end
        if (grant && (grant_vc == NumVCWidth'(v))) begin
          if (req_head_i && !req_last_i) begin
            busy_q[v]  <= 1'b1;
            owner_q[v] <= req_input_id_i;
          end else if (!req_head_i && req_last_i) begin
            busy_q[v]  <= 1'b0;
          end
        end
      end
    end
  end

  a_body_without_vc : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(req_v_i && !req_head_i && !own_found));
  a_head_while_owning : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(req_v_i && req_head_i && own_found));
  a_credit_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !credit_overflow);
  a_credit_id_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(credit_v_i && (int'(credit_id_i) >= NumVC)));

endmodule

// File: tb/tb_floo_vc_output_alloc.sv
module tb_floo_vc_output_alloc;
  localparam int NumVC   = 4;
  localparam int VCDepth = 2;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       req_v_i, req_head_i, req_last_i, credit_v_i;
  logic [2:0] req_input_id_i;
  logic [1:0] req_pref_vc_i, credit_id_i;
  logic       vc_assignment_v_o, st_v_o;
  logic [1:0] vc_assignment_id_o, st_vc_id_o;
  logic [2:0] st_input_id_o;
  logic [3:0] vc_busy_o;
  logic [7:0] credit_counter_o;

  floo_vc_output_alloc dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_v_i(req_v_i), .req_input_id_i(req_input_id_i), .req_head_i(req_head_i),
    .req_last_i(req_last_i), .req_pref_vc_i(req_pref_vc_i),
    .credit_v_i(credit_v_i), .credit_id_i(credit_id_i),
    .vc_assignment_v_o(vc_assignment_v_o), .vc_assignment_id_o(vc_assignment_id_o),
    .st_v_o(st_v_o), .st_vc_id_o(st_vc_id_o), .st_input_id_o(st_input_id_o),
    .vc_busy_o(vc_busy_o), .credit_counter_o(credit_counter_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_busy [NumVC];
  int m_owner[NumVC];
  int m_cred [NumVC];
  int m_stv, m_stvc, m_stin;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NumVC; v++) begin
      m_busy[v] = 0; m_owner[v] = 0; m_cred[v] = VCDepth;
    end
    m_stv = 0; m_stvc = 0; m_stin = 0;
  endtask

  function automatic int owned_vc(input int id);
    for (int v = 0; v < NumVC; v++)
      if (m_busy[v] != 0 && m_owner[v] == id) return v;
    return -1;
  endfunction

  // Returns granted VC or -1.
  function automatic int model_grant(input logic v, input int id, input logic head,
                                     input int pref);
    int own;
    int ok[$];
    if (!v) return -1;
    own = owned_vc(id);
    if (head) begin
      if (own >= 0) return -1;
      for (int c = 0; c < NumVC; c++)
        if (m_busy[c] == 0 && m_cred[c] > 0) ok.push_back(c);
      if (ok.size() == 0) return -1;
      foreach (ok[i]) if (ok[i] == pref) return pref;
      return ok[0];
    end
    if (own >= 0 && m_cred[own] > 0) return own;
    return -1;
  endfunction

  task automatic model_update(input int g, input int id, input logic head, input logic last,
                              input logic cv, input int cid);
    if (cv && !(m_cred[cid] == VCDepth && g != cid)) m_cred[cid] += 1;
    if (g >= 0) begin
      m_cred[g] -= 1;
      if (head && !last) begin m_busy[g] = 1; m_owner[g] = id; end
      else if (!head && last) m_busy[g] = 0;
      m_stvc = g; m_stin = id;
    end
    m_stv = (g >= 0);
  endtask

  task automatic check_state(input string tag);
    logic [3:0] eb;
    logic [7:0] ec;
    for (int v = 0; v < NumVC; v++) begin
      eb[v] = (m_busy[v] != 0);
      ec[v*2 +: 2] = 2'(m_cred[v]);
    end
    check({tag, ".busy"},   32'(vc_busy_o), 32'(eb));
    check({tag, ".credit"}, 32'(credit_counter_o), 32'(ec));
    check({tag, ".st_v"},   32'(st_v_o), 32'(m_stv));
    check({tag, ".st_vc"},  32'(st_vc_id_o), 32'(m_stvc));
    check({tag, ".st_in"},  32'(st_input_id_o), 32'(m_stin));
  endtask

  // One clock cycle: inputs applied just after an edge, grant checked mid-cycle,
  // registered state checked just after the next edge.
  task automatic cycle(input logic v, input int id, input logic head, input logic last,
                       input int pref, input logic cv, input int cid,
                       input logic use_exp, input logic egv, input int egid,
                       input string tag);
    int g;
    req_v_i = v; req_input_id_i = 3'(id); req_head_i = head; req_last_i = last;
    req_pref_vc_i = 2'(pref); credit_v_i = cv; credit_id_i = 2'(cid);
    g = model_grant(v, id, head, pref);
    #3;
    if (use_exp) begin
      check({tag, ".gv"},  32'(vc_assignment_v_o), 32'(egv));
      check({tag, ".gid"}, 32'(vc_assignment_id_o), 32'(egv ? egid : 0));
    end else begin
      check({tag, ".gv"},  32'(vc_assignment_v_o), 32'(g >= 0));
      check({tag, ".gid"}, 32'(vc_assignment_id_o), 32'(g >= 0 ? g : 0));
    end
    @(posedge clk_i); #1;
    model_update(g, id, head, last, cv, cid);
    check_state(tag);
  endtask

  typedef struct {
    logic v; int id; logic head; logic last; int pref;
    logic cv; int cid; logic egv; int egid;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input int id, input logic head, input logic last,
                              input int pref, input logic cv, input int cid,
                              input logic egv, input int egid);
    vec_t r;
    r.v = v; r.id = id; r.head = head; r.last = last; r.pref = pref;
    r.cv = cv; r.cid = cid; r.egv = egv; r.egid = egid;
    return r;
  endfunction

  task automatic do_reset();
    rst_ni = 1'b0;
    req_v_i = 0; req_input_id_i = 0; req_head_i = 0; req_last_i = 0;
    req_pref_vc_i = 0; credit_v_i = 0; credit_id_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    //            v  id h  l  pf cv cid egv egid
    tbl.push_back(mk(1, 2, 1, 0, 1, 0, 0, 1, 1));  // head id2 pref1
    tbl.push_back(mk(1, 2, 0, 0, 0, 0, 0, 1, 1));  // body, credit1 -> 0
    tbl.push_back(mk(1, 2, 0, 1, 0, 0, 0, 0, 0));  // tail waits on credit
    tbl.push_back(mk(1, 2, 0, 1, 0, 1, 1, 0, 0));  // returning credit not granted through
    tbl.push_back(mk(1, 2, 0, 1, 0, 0, 0, 1, 1));  // tail granted, VC1 freed
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));  // refill VC1
    tbl.push_back(mk(1, 2, 1, 0, 1, 0, 0, 1, 1));  // relock VC1 by id2
    tbl.push_back(mk(1, 3, 1, 0, 1, 0, 0, 1, 0));  // pref busy -> lowest VC0
    tbl.push_back(mk(1, 4, 1, 0, 0, 0, 0, 1, 2));  // VC0,1 busy -> VC2
    tbl.push_back(mk(1, 1, 1, 1, 3, 0, 0, 1, 3));  // single flit on VC3
    tbl.push_back(mk(1, 0, 1, 0, 3, 0, 0, 1, 3));  // lock VC3
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));  // all busy -> no grant
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2, 0, 0));  // refill VC2 to 2
    tbl.push_back(mk(1, 4, 0, 0, 0, 1, 2, 1, 2));  // body + credit same VC -> stays 2
    tbl.push_back(mk(1, 3, 0, 1, 0, 0, 0, 1, 0));  // tail on VC0 frees it, credit 0
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));  // free VC0 has no credit
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));  // tail on VC3 lacks credit

    do_reset();
    check_state("reset");

    for (int i = 0; i < tbl.size(); i++)
      cycle(tbl[i].v, tbl[i].id, tbl[i].head, tbl[i].last, tbl[i].pref,
            tbl[i].cv, tbl[i].cid, 1'b1, tbl[i].egv, tbl[i].egid, $sformatf("vec%0d", i));

    // Asynchronous reset while VC0 and VC3 are locked.
    do_reset();
    cycle(1, 0, 1, 0, 0, 0, 0, 1'b1, 1, 0, "rst_lock0");
    cycle(1, 1, 1, 0, 3, 0, 0, 1'b1, 1, 3, "rst_lock3");
    req_v_i = 0;
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    check("async_rst.busy",   32'(vc_busy_o), 32'h0);
    check("async_rst.credit", 32'(credit_counter_o), 32'hAA);
    check("async_rst.st_v",   32'(st_v_o), 32'h0);
    check("async_rst.st_vc",  32'(st_vc_id_o), 32'h0);
    check("async_rst.st_in",  32'(st_input_id_o), 32'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    cycle(1, 1, 1, 0, 3, 0, 0, 1'b1, 1, 3, "post_rst");

    // Randomized legal traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic v, head, last, cv;
      int id, pref, cid;
      v    = ($urandom_range(0, 3) != 0);
      id   = $urandom_range(0, 4);
      head = (owned_vc(id) < 0);
      last = $urandom_range(0, 1);
      pref = $urandom_range(0, 3);
      cid  = $urandom_range(0, 3);
      cv   = ($urandom_range(0, 1) != 0) && (m_cred[cid] < VCDepth);
      cycle(v, id, head, last, pref, cv, cid, 1'b0, 0, 0, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
